perf_counter_sampler: RTL

- Controller for the performance event counter bank: decides when counter values are sampled, snapshots all counters in one cycle, clears the bank, then drains the snapshot one counter per beat over a valid/ready stream.
- Sits between the counter bank and the monitoring export path (trace/host FIFO).
- Supports periodic sampling (programmable period) and manual sampling (`sample_now`).
- Counts sample requests lost while a drain is in progress.

---
 rtl/perf_sampler_pkg.sv | 35 +++
 rtl/perf_counter_sampler_timer.sv | 33 +++
 rtl/perf_counter_sampler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/perf_sampler_pkg.sv
// Shared types and helpers for the performance counter sampler.
//   state_t     : sampler FSM states (IDLE, DRAIN)
//   idx_width() : counter-index width, $clog2(n) with a floor of 1
//   get_counter : extracts counter k of width w from a flattened bank
package perf_sampler_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // Upper bounds for the generic extraction helper; callers zero-extend
    // their flattened bank to MAX_FLAT_W and truncate the result.
    localparam int unsigned MAX_FLAT_W = 4096;
    localparam int unsigned MAX_CNT_W  = 64;

    localparam int unsigned DEFAULT_NUM_COUNTERS = 7;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_width(DEFAULT_NUM_COUNTERS);

    function automatic logic [MAX_CNT_W-1:0] get_counter(
        input logic [MAX_FLAT_W-1:0] flat,
        input int unsigned           k,
        input int unsigned           w
    );
        logic [MAX_CNT_W-1:0] mask;
        mask = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
        return MAX_CNT_W'(flat >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/perf_counter_sampler_timer.sv
// Periodic sample timer.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : timer runs only while high; low holds count at 0
//   sample_period : cycles between expiries; 0 disables the timer
//   expire        : high in the cycle the period elapses
module perf_sample_timer #(
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PERIOD_WIDTH-1:0] sample_period,
    output logic                    expire
);

    logic [PERIOD_WIDTH-1:0] count;

    // ">=" so that shrinking the period below the current count expires
    // on the next cycle instead of waiting for a wrap.
    assign expire = en && (sample_period != '0) &&
                    (count >= sample_period - PERIOD_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || (sample_period == '0) || expire) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/perf_counter_sampler.sv
// Performance counter sampler: on a manual or periodic trigger, snapshots
// the whole counter bank, pulses counters_clear, then drains the snapshot
// one counter per valid/ready beat. Triggers arriving during a drain are
// counted in a saturating dropped counter.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : enables timer and triggers
//   sample_period   : periodic trigger interval (0 = off)
//   sample_now      : manual trigger pulse
//   counters_flat   : counter k at [k*COUNTER_WIDTH +: COUNTER_WIDTH]
//   counters_clear  : one-cycle clear to the bank after a capture
//   out_valid/ready : snapshot stream handshake
//   out_data/index  : snapshot value and counter number of the beat
//   out_last        : final beat of the snapshot
//   busy            : snapshot draining
//   dropped         : saturating count of triggers lost while busy
module perf_counter_sampler
    import perf_sampler_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS  = 7,
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned PERIOD_WIDTH  = 32,
    parameter int unsigned DROP_WIDTH    = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic [PERIOD_WIDTH-1:0]                 sample_period,
    input  logic                                    sample_now,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   counters_flat,
    output logic                                    counters_clear,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [COUNTER_WIDTH-1:0]                out_data,
    output logic [idx_width(NUM_COUNTERS)-1:0]      out_index,
    output logic                                    out_last,
    output logic                                    busy,
    output logic [DROP_WIDTH-1:0]                   dropped
);

    localparam int unsigned       IDX_W    = idx_width(NUM_COUNTERS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] snap [NUM_COUNTERS];
    logic                     expire;
    logic                     trigger;
    logic [IDX_W-1:0]         nxt_idx;

    perf_sample_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sample_period (sample_period),
        .expire        (expire)
    );

    // Coincident manual and periodic events collapse into one trigger.
    assign trigger = en && (sample_now || expire);
    assign nxt_idx = out_index + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            counters_clear <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_index      <= '0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            dropped        <= '0;
            for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                snap[k] <= '0;
            end
        end else begin
            counters_clear <= 1'b0;

            // Still DRAIN on the last handshake, so a trigger there is lost.
            if (trigger && (state == DRAIN) && (dropped != '1)) begin
                dropped <= dropped + DROP_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                            snap[k] <= COUNTER_WIDTH'(get_counter(
                                MAX_FLAT_W'(counters_flat), k, COUNTER_WIDTH));
                        end
                        // First beat is presented straight from the bank.
                        out_data       <= COUNTER_WIDTH'(get_counter(
                                              MAX_FLAT_W'(counters_flat), 0, COUNTER_WIDTH));
                        out_index      <= '0;
                        out_last       <= (LAST_IDX == '0);
                        out_valid      <= 1'b1;
                        busy           <= 1'b1;
                        counters_clear <= 1'b1;
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            state     <= IDLE;
                        end else begin
                            out_index <= nxt_idx;
                            out_data  <= snap[nxt_idx];
                            out_last  <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
